// File: rtl/spi_pkg.sv
// spi_pkg -- definitions shared by both ends of the SPI link.
//
// Contents:
//   spi_state_t    IDLE / ACTIVE link state
//   SPI_CPOL       clock polarity of the link (mode 0)
//   SPI_CPHA       clock phase of the link (mode 0)
//   SPI_MSB_FIRST  bit order on the wire
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam bit SPI_CPOL      = 1'b0;
    localparam bit SPI_CPHA      = 1'b0;
    localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge -- multi-flop synchronizer for one asynchronous input, plus
// one-cycle rise/fall strobes derived from the synchronized value.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth (>= 2)
//   RESET_VAL    value of every flop while rst_n is low
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input
//   dout   out  synchronized input
//   rise   out  one-cycle strobe: dout went 0 -> 1
//   fall   out  one-cycle strobe: dout went 1 -> 0
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave -- SPI mode 0 (CPOL=0, CPHA=0) peripheral endpoint, MSB first,
// full duplex, any number of back-to-back words per chip-select frame.
// SCK, CS_N and MOSI are oversampled on clk; SCK high and low times must each
// be at least SYNC_STAGES+2 clk cycles.
//
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN (adds frame_err output).
//
// Parameters:
//   DATA_LENGTH  bits per word (>= 2)
//   SYNC_STAGES  synchronizer depth (>= 2)
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   spi_sck    in   serial clock from master (asynchronous)
//   spi_cs_n   in   chip select, active low
//   spi_mosi   in   serial data from master
//   spi_miso   out  serial data to master
//   tx_data    in   next word to transmit, captured when tx_ack pulses
//   tx_ack     out  one-cycle pulse: tx_data captured
//   rx_data    out  last complete received word
//   rx_valid   out  one-cycle pulse: rx_data updated
//   busy       out  high while selected
//   frame_err  out  (macro only) one-cycle pulse: frame ended mid-word or
//                   without any complete word
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sck,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    input  logic [DATA_LENGTH-1:0] tx_data,
    output logic                   tx_ack,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int CNT_W = $clog2(DATA_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

    spi_state_t state, state_next;

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall, unused_sck_s, unused_cs_s;

    // The bit currently on spi_miso is held in spi_miso itself, so the
    // shifters only keep the remaining DATA_LENGTH-1 bits.
    logic [DATA_LENGTH-2:0] tx_shift;
    logic [DATA_LENGTH-2:0] rx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   word_end;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic                   got_word;
`endif

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .din(spi_sck),
        .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    // MOSI goes through the same depth as SCK so data and clock stay aligned.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign unused_sck_s = sck_s;
    assign unused_cs_s  = cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                busy = 1'b1;
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_miso <= 1'b0;
            tx_ack   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            word_end <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b0;
            got_word  <= 1'b0;
`endif
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (state == IDLE) begin
                spi_miso <= 1'b0;
                if (cs_fall) begin
                    spi_miso <= tx_data[DATA_LENGTH-1];
                    tx_shift <= tx_data[DATA_LENGTH-2:0];
                    tx_ack   <= 1'b1;
                    bit_cnt  <= '0;
                    word_end <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    got_word <= 1'b0;
`endif
                end
            end else begin
                // cs_rise takes priority over any coincident SCK edge.
                if (cs_rise) begin
                    spi_miso <= 1'b0;
                    bit_cnt  <= '0;
                    word_end <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                    frame_err <= (bit_cnt != '0) || !got_word;
`endif
                end else if (sck_rise) begin
                    rx_shift <= (DATA_LENGTH-1)'({rx_shift, mosi_s});
                    if (bit_cnt == LAST_BIT) begin
                        rx_data  <= {rx_shift, mosi_s};
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        word_end <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        got_word <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (word_end) begin
                        // Word boundary: the next word goes out on this fall.
                        spi_miso <= tx_data[DATA_LENGTH-1];
                        tx_shift <= tx_data[DATA_LENGTH-2:0];
                        tx_ack   <= 1'b1;
                        word_end <= 1'b0;
                    end else begin
                        spi_miso <= tx_shift[DATA_LENGTH-2];
                        tx_shift <= tx_shift << 1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sck, mosi, cs8, cs16;
    logic        miso8, miso16;
    logic [7:0]  tx8, rx8;
    logic [15:0] tx16, rx16;
    logic        ack8, ack16, rxv8, rxv16, busy8, busy16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic        ferr8, ferr16;
`endif

    spi_slave #(.DATA_LENGTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs8),
        .spi_mosi(mosi), .spi_miso(miso8), .tx_data(tx8), .tx_ack(ack8),
        .rx_data(rx8), .rx_valid(rxv8), .busy(busy8)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(ferr8)
`endif
    );

    spi_slave #(.DATA_LENGTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs16),
        .spi_mosi(mosi), .spi_miso(miso16), .tx_data(tx16), .tx_ack(ack16),
        .rx_data(rx16), .rx_valid(rxv16), .busy(busy16)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        , .frame_err(ferr16)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int ferr_cnt = 0;
    logic [15:0] exp_rx[$];
    logic [15:0] obs_rx[$];

    // Observer: collects received words and counts pulses away from posedge.
    always @(negedge clk) begin
        if (rxv8)  obs_rx.push_back({8'h00, rx8});
        if (rxv16) obs_rx.push_back(rx16);
        if (ack8)  ack_cnt = ack_cnt + 1;
        if (ack16) ack_cnt = ack_cnt + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (ferr8 || ferr16) ferr_cnt = ferr_cnt + 1;
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-banged mode-0 master. The last SCK fall coincides with CS rising.
    task automatic xfer(input bit wide, input int n, input int nwords,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] next_tx, input int half,
                        output logic [15:0] r0, output logic [15:0] r1);
        logic [15:0] w;
        logic [15:0] r;
        r0 = '0;
        r1 = '0;
        if (wide) cs16 = 1'b0; else cs8 = 1'b0;
        mosi = w0[n-1];
        cyc(6);
        if (wide) tx16 = next_tx; else tx8 = next_tx[7:0];
        for (int k = 0; k < nwords; k++) begin
            w = (k == 0) ? w0 : w1;
            r = '0;
            for (int i = n - 1; i >= 0; i--) begin
                mosi = w[i];
                cyc(half);
                sck = 1'b1;
                r[i] = wide ? miso16 : miso8;
                cyc(half);
                sck = 1'b0;
                if (k == nwords - 1 && i == 0) begin
                    if (wide) cs16 = 1'b1; else cs8 = 1'b1;
                end
            end
            if (k == 0) r0 = r; else r1 = r;
        end
        cyc(8);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sck = 1'b0; mosi = 1'b0; cs8 = 1'b1; cs16 = 1'b1;
        tx8 = 8'h00; tx16 = 16'h0000;
        cyc(3);
        checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso8); end
        checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx8); end
        checks++; if (rxv8 !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rxv8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
        rst_n = 1'b1;
        cyc(4);
    endtask

    task automatic test_single;
        logic [15:0] r0, r1;
        int a0;
        tx8 = 8'h3C;
        a0 = ack_cnt;
        exp_rx.push_back(16'h00A5);
        xfer(1'b0, 8, 1, 16'h00A5, 16'h0000, 16'h003C, 4, r0, r1);
        checks++; if (r0[7:0] !== 8'h3C) begin errors++; $display("FAIL single_miso got %h exp 3c", r0[7:0]); end
        checks++; if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL single_ack_count got %0d exp 1", ack_cnt - a0); end
        checks++; if (obs_rx.size() !== exp_rx.size()) begin errors++; $display("FAIL single_rx_count got %0d exp %0d", obs_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rx.pop_front(); o = obs_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_rx_word got %h exp %h", o, e); end
        end
        exp_rx.delete(); obs_rx.delete();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy8); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r0, r1;
        int a0;
        tx8 = 8'h3C;
        a0 = ack_cnt;
        exp_rx.push_back(16'h0001);
        exp_rx.push_back(16'h00FE);
        xfer(1'b0, 8, 2, 16'h0001, 16'h00FE, 16'h0081, 4, r0, r1);
        checks++; if (r0[7:0] !== 8'h3C) begin errors++; $display("FAIL b2b_miso0 got %h exp 3c", r0[7:0]); end
        checks++; if (r1[7:0] !== 8'h81) begin errors++; $display("FAIL b2b_miso1 got %h exp 81", r1[7:0]); end
        checks++; if (ack_cnt - a0 !== 2) begin errors++; $display("FAIL b2b_ack_count got %0d exp 2", ack_cnt - a0); end
        checks++; if (obs_rx.size() !== exp_rx.size()) begin errors++; $display("FAIL b2b_rx_count got %0d exp %0d", obs_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rx.pop_front(); o = obs_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL b2b_rx_word got %h exp %h", o, e); end
        end
        exp_rx.delete(); obs_rx.delete();
    endtask

    task automatic test_abort;
        int f0;
        f0 = ferr_cnt;
        tx8 = 8'h55;
        cs8 = 1'b0;
        mosi = 1'b1;
        cyc(6);
        // five SCK edges: rise, fall, rise, fall, rise
        for (int e = 0; e < 5; e++) begin
            sck = ~sck;
            cyc(4);
        end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL abort_busy_mid got %b exp 1", busy8); end
        cs8 = 1'b1;
        cyc(4);
        sck = 1'b0;
        cyc(8);
        checks++; if (obs_rx.size() !== 0) begin errors++; $display("FAIL abort_rx_valid got %0d words exp 0", obs_rx.size()); end
        checks++; if (rx8 !== 8'hFE) begin errors++; $display("FAIL abort_rx_hold got %h exp fe", rx8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy_end got %b exp 0", busy8); end
        checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL abort_miso_end got %b exp 0", miso8); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL abort_frame_err got %0d cycles exp 1", ferr_cnt - f0); end
`else
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL abort_frame_err got %0d cycles exp 0", ferr_cnt - f0); end
`endif
        obs_rx.delete();
    endtask

    task automatic test_reset_mid;
        logic [15:0] r0, r1;
        tx8 = 8'hFF;
        cs8 = 1'b0;
        mosi = 1'b1;
        cyc(6);
        for (int b = 0; b < 3; b++) begin
            sck = 1'b1; cyc(4);
            sck = 1'b0; cyc(4);
        end
        checks++; if (miso8 !== 1'b1) begin errors++; $display("FAIL rstmid_miso_before got %b exp 1", miso8); end
        rst_n = 1'b0;
        #1;
        checks++; if (miso8 !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b exp 0", miso8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got %h exp 00", rx8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy8); end
        cs8 = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        checks++; if (obs_rx.size() !== 0) begin errors++; $display("FAIL rstmid_rx_valid got %0d words exp 0", obs_rx.size()); end
        obs_rx.delete();
        tx8 = 8'hC3;
        exp_rx.push_back(16'h005A);
        xfer(1'b0, 8, 1, 16'h005A, 16'h0000, 16'h00C3, 4, r0, r1);
        checks++; if (r0[7:0] !== 8'hC3) begin errors++; $display("FAIL rstmid_after_miso got %h exp c3", r0[7:0]); end
        checks++; if (obs_rx.size() !== exp_rx.size()) begin errors++; $display("FAIL rstmid_after_count got %0d exp %0d", obs_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rx.pop_front(); o = obs_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL rstmid_after_word got %h exp %h", o, e); end
        end
        exp_rx.delete(); obs_rx.delete();
    endtask

    task automatic test_idle_sck;
        int a0;
        logic bad_miso, bad_busy;
        a0 = ack_cnt;
        bad_miso = 1'b0;
        bad_busy = 1'b0;
        cs8 = 1'b1; cs16 = 1'b1;
        for (int t = 0; t < 20; t++) begin
            sck = ~sck;
            mosi = t[1];
            for (int c = 0; c < 4; c++) begin
                cyc(1);
                bad_miso = bad_miso | miso8 | miso16;
                bad_busy = bad_busy | busy8 | busy16;
            end
        end
        sck = 1'b0;
        cyc(6);
        checks++; if (obs_rx.size() !== 0) begin errors++; $display("FAIL idle_rx_valid got %0d words exp 0", obs_rx.size()); end
        checks++; if (ack_cnt - a0 !== 0) begin errors++; $display("FAIL idle_tx_ack got %0d exp 0", ack_cnt - a0); end
        checks++; if (bad_miso !== 1'b0) begin errors++; $display("FAIL idle_miso got %b exp 0", bad_miso); end
        checks++; if (bad_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bad_busy); end
        obs_rx.delete();
    endtask

    task automatic test_min_timing;
        logic [15:0] r0, r1;
        tx16 = 16'hBEEF;
        exp_rx.push_back(16'hBEEF);
        xfer(1'b1, 16, 1, 16'hBEEF, 16'h0000, 16'hBEEF, 4, r0, r1);
        checks++; if (r0 !== 16'hBEEF) begin errors++; $display("FAIL min16_miso got %h exp beef", r0); end
        checks++; if (obs_rx.size() !== exp_rx.size()) begin errors++; $display("FAIL min16_rx_count got %0d exp %0d", obs_rx.size(), exp_rx.size()); end
        while (exp_rx.size() > 0 && obs_rx.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rx.pop_front(); o = obs_rx.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL min16_rx_word got %h exp %h", o, e); end
        end
        exp_rx.delete(); obs_rx.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_idle_sck();
        test_min_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (slave) endpoint, mode 0 (CPOL=0, CPHA=0), MSB-first.
- Sits on the far end of the team's SPI master link and hands received words to local logic.
- Oversamples the external spi_sck, spi_cs_n and spi_mosi on the system clock through 2-FF synchronizers.
- Returns local transmit data on spi_miso, full-duplex, with multiple back-to-back words per chip-select frame.

Parameters:
- DATA_LENGTH, 8, bits per word (minimum 2).
- SYNC_STAGES, 2, synchronizer depth for spi_sck, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- spi_sck  input  1  serial clock from the master; asynchronous to clk.
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  serial data from the master.
- spi_miso  output  1  serial data to the master.
- tx_data  input  DATA_LENGTH  next word to transmit; sampled when tx_ack pulses.
- tx_ack  output  1  one-cycle pulse: tx_data captured; local logic may present the next word.
- rx_data  output  DATA_LENGTH  last complete received word.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  high while selected (state ACTIVE).

Behaviour:
- Reset: everything clears asynchronously on rst_n low. Reset values: spi_miso=0, tx_ack=0, rx_data=0, rx_valid=0, busy=0, shift registers=0, bit_cnt=0, state=IDLE. Synchronizer flops reset to sck=0, cs_n=1, mosi=0. Reset mid-frame aborts the frame with no rx_valid.
- Synchronization and edge detection: sck_rise and sck_fall are 1-cycle strobes derived from the synchronized SCK and its previous value. cs_fall and cs_rise are derived the same way from the synchronized CS.
- Timing requirement: SCK high and low times must each be at least SYNC_STAGES+2 clk cycles. The team master's default CLK_DIV=4 satisfies this.
- Latency: input-to-action latency is SYNC_STAGES+1 clk cycles.
- State IDLE:
  - busy=0, spi_miso=0.
  - On cs_fall: load tx_shift<=tx_data, drive spi_miso<=tx_data[MSB], pulse tx_ack, clear bit_cnt, go to ACTIVE.
- State ACTIVE (busy=1):
  - On sck_rise: rx_shift<={rx_shift[DATA_LENGTH-2:0], mosi_s}; bit_cnt++.
  - If bit_cnt was DATA_LENGTH-1 on that sck_rise: rx_data<={rx_shift[DATA_LENGTH-2:0], mosi_s}; rx_valid pulses in the same cycle rx_data updates; bit_cnt wraps to 0; set word_end.
  - On sck_fall with word_end=0: shift tx_shift left; spi_miso<=next bit.
  - On sck_fall with word_end=1: reload tx_shift<=tx_data; spi_miso<=tx_data[MSB]; pulse tx_ack; clear word_end.
  - On cs_rise: go to IDLE; spi_miso<=0; discard the partial word (no rx_valid); bit_cnt<=0.
  - Simultaneous cs_rise and sck edge: cs_rise wins; the edge is ignored.
- bit_cnt width: $clog2(DATA_LENGTH); the counter never exceeds DATA_LENGTH-1.
- SCK edges while in IDLE are ignored.
- rx_data holds its value until the next complete word.
- tx_data is never consumed without a tx_ack pulse. Local logic must keep tx_data stable from one tx_ack until the next word boundary.

Optional Feature:
- Macro: SPI_SLAVE_FRAME_ERR_EN.
- When defined: adds output frame_err (1 bit, reset 0). frame_err pulses one cycle when cs_rise occurs with bit_cnt!=0, i.e. the master aborted mid-word. It also pulses when cs_rise occurs with no complete word received in the frame.
- When undefined: the port and logic are absent; aborts are silently discarded.

Decomposition:
- Package spi_pkg: shared SPI state enum (IDLE/ACTIVE) and a MODE0/MSB_FIRST constant, shared with the master.
- One natural sub-module: spi_sync_edge, a SYNC_STAGES synchronizer plus rise/fall strobe generator. It is instantiated three times (sck, cs_n, mosi; edges unused for mosi).

Test Plan:
- Single word: master sends 8'hA5 with tx_data=8'h3C. Required: rx_data=8'hA5 with one rx_valid pulse; master receives 8'h3C; exactly one tx_ack after cs_fall.
- Back-to-back: one CS frame carries 8'h01 then 8'hFE; tx_data changes to 8'h81 after the first tx_ack. Required: two rx_valid pulses (01, FE); master receives 3C then 81; two tx_ack pulses total.
- Abort: CS deasserted after 5 SCK edges. Required: no rx_valid; rx_data keeps its prior value; busy falls; frame_err=1 for one cycle with the macro, port absent without it.
- Reset mid-word: rst_n pulsed low at bit 3. Required: all outputs at reset values immediately; the next full frame 8'h5A is received correctly.
- Idle SCK: SCK toggled with CS high. Required: no rx_valid, no tx_ack, spi_miso=0, busy=0.
- Minimum SCK timing: SCK half-period of exactly 4 clk, 16-bit instance, data 16'hBEEF both directions. Required: bit-exact exchange.
